// File: rtl/pll_cfg_seq.sv
// iCE40UP PLL configuration sequencer: encodes N/M/O, sequences PD, waits for lock with retry.
// Build option: define PLL_CFG_SEQ_RELOCK_EN to re-run power-down/lock after losing lock.
//
// state       | meaning
// ------------+-----------------------------------------------------------
// S_IDLE      | reset state, PD high, waiting for a config
// S_ENCODE    | stepping the CN LFSR; codes are applied on the last cycle
// S_PWRDN     | PD held high for PD_CYCLES with the new codes applied
// S_WAIT_LOCK | PD low, filtering LOCK, timeout running
// S_LOCKED    | lock declared, monitoring LOCK
// S_FAIL      | out of attempts or lock lost, PD high, fail set
module pll_cfg_seq #(
    parameter int PD_CYCLES    = 16,
    parameter int LOCK_FILTER  = 8,
    parameter int LOCK_TIMEOUT = 4000000,
    parameter int TMO_W        = 24,
    parameter int MAX_RETRY    = 3
) (
    input  logic       CLK,
    input  logic       RST,
    input  logic       cfg_valid,
    output logic       cfg_ready,
    input  logic [5:0] cfg_n,
    input  logic [7:0] cfg_m,
    input  logic [3:0] cfg_o,
    output logic       cfg_err,
    output logic       PD,
    output logic [4:0] CN,
    output logic [7:0] CM,
    output logic [1:0] CO,
    input  logic       LOCK,
    output logic       locked,
    output logic       fail,
    output logic [3:0] retries
);

    localparam int FLT_W = $clog2(LOCK_FILTER + 1);
    localparam logic [3:0] MAX_R = 4'(MAX_RETRY);

    typedef enum logic [2:0] {
        S_IDLE,
        S_ENCODE,
        S_PWRDN,
        S_WAIT_LOCK,
        S_LOCKED,
        S_FAIL
    } state_t;

    state_t state, state_nxt;

    logic             lock_m, lock_s;
    logic [5:0]       n_q;
    logic [7:0]       m_q;
    logic [3:0]       o_q;
    logic [4:0]       lfsr;
    logic [TMO_W-1:0] tmr;
    logic [FLT_W-1:0] flt;
    logic             accept, cfg_legal, start, tmr_tc, last_enc, flt_done;
    logic [4:0]       cn_enc;
    logic [7:0]       cm_enc;
    logic [1:0]       co_enc;

    always_comb begin
        cfg_ready = (state == S_IDLE) || (state == S_LOCKED) || (state == S_FAIL);
        cfg_legal = (cfg_n >= 6'd1) && (cfg_n <= 6'd32) && (cfg_m >= 8'd16) &&
                    ((cfg_o == 4'd1) || (cfg_o == 4'd2) || (cfg_o == 4'd4) || (cfg_o == 4'd8));
        accept    = cfg_valid && cfg_ready;
        start     = accept && cfg_legal;
        tmr_tc    = (tmr == '0);
        last_enc  = (state == S_ENCODE) && tmr_tc;
        flt_done  = lock_s && (flt == FLT_W'(LOCK_FILTER - 1));
    end

    // M range is identified by its leading one; the remainder is M minus the range base.
    always_comb begin
        cn_enc = (n_q == 6'd1) ? 5'b11111 : lfsr;
        if (m_q[7])      cm_enc = {1'b0, m_q[6:0]};
        else if (m_q[6]) cm_enc = {2'b10, m_q[5:0]};
        else if (m_q[5]) cm_enc = {3'b110, m_q[4:0]};
        else             cm_enc = {4'b1111, m_q[3:0]};
        case (o_q)
            4'd2:    co_enc = 2'b01;
            4'd4:    co_enc = 2'b10;
            4'd8:    co_enc = 2'b11;
            default: co_enc = 2'b00;
        endcase
    end

    always_ff @(posedge CLK) begin
        if (RST) state <= S_IDLE;
        else     state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        if (start) begin
            state_nxt = S_ENCODE;
        end else begin
            case (state)
                S_IDLE:      state_nxt = S_IDLE;
                S_ENCODE:    if (tmr_tc) state_nxt = S_PWRDN;
                S_PWRDN:     if (tmr_tc) state_nxt = S_WAIT_LOCK;
                S_WAIT_LOCK: begin
                    if (flt_done)    state_nxt = S_LOCKED;
                    else if (tmr_tc) state_nxt = (retries < MAX_R) ? S_PWRDN : S_FAIL;
                end
                S_LOCKED: begin
                    if (!lock_s) begin
`ifdef PLL_CFG_SEQ_RELOCK_EN
                        state_nxt = (retries < MAX_R) ? S_PWRDN : S_FAIL;
`else
                        state_nxt = S_FAIL;
`endif
                    end
                end
                S_FAIL:      state_nxt = S_FAIL;
                default:     state_nxt = S_IDLE;
            endcase
        end
    end

    // One down-counter serves ENCODE steps, PD hold and lock timeout; it reloads on every state change.
    always_ff @(posedge CLK) begin
        if (RST) begin
            lock_m  <= 1'b0;
            lock_s  <= 1'b0;
            n_q     <= 6'd0;
            m_q     <= 8'd0;
            o_q     <= 4'd0;
            lfsr    <= 5'd0;
            tmr     <= '0;
            flt     <= '0;
            cfg_err <= 1'b0;
            PD      <= 1'b1;
            CN      <= 5'b11111;
            CM      <= 8'b11110000;
            CO      <= 2'b00;
            locked  <= 1'b0;
            fail    <= 1'b0;
            retries <= 4'd0;
        end else begin
            lock_m  <= LOCK;
            lock_s  <= lock_m;
            cfg_err <= accept && !cfg_legal;

            if (start) begin
                n_q  <= cfg_n;
                m_q  <= cfg_m;
                o_q  <= cfg_o;
                lfsr <= 5'd0;
            end else if ((state == S_ENCODE) && !tmr_tc) begin
                lfsr <= {lfsr[3:0], ~(lfsr[4] ^ lfsr[2])};
            end

            if (state_nxt != state) begin
                case (state_nxt)
                    S_ENCODE:    tmr <= (cfg_n >= 6'd2) ? TMO_W'(cfg_n - 6'd2) : '0;
                    S_PWRDN:     tmr <= TMO_W'(PD_CYCLES - 1);
                    S_WAIT_LOCK: tmr <= TMO_W'(LOCK_TIMEOUT - 1);
                    default:     tmr <= '0;
                endcase
            end else if (!tmr_tc) begin
                tmr <= tmr - TMO_W'(1);
            end

            if ((state != S_WAIT_LOCK) || !lock_s) flt <= '0;
            else                                   flt <= flt + FLT_W'(1);

            if (last_enc) begin
                CN <= cn_enc;
                CM <= cm_enc;
                CO <= co_enc;
            end

            if (start)
                retries <= 4'd0;
            else if ((state_nxt == S_WAIT_LOCK) && (state != S_WAIT_LOCK))
                retries <= retries + 4'd1;

            PD     <= !((state_nxt == S_WAIT_LOCK) || (state_nxt == S_LOCKED));
            locked <= (state_nxt == S_LOCKED);
            fail   <= (state_nxt == S_FAIL);
        end
    end

endmodule

// File: tb/tb_pll_cfg_seq.sv
// Bench for pll_cfg_seq: randomized configs, a simple PLL lock model and an event scoreboard.
module tb_pll_cfg_seq;

    localparam int PD_C = 16;
    localparam int FLT  = 8;
    localparam int TMO  = 100;
    localparam int MAXR = 3;

    localparam int EV_ERR    = 0;
    localparam int EV_PDFALL = 1;
    localparam int EV_LOCK   = 2;
    localparam int EV_UNLOCK = 3;
    localparam int EV_FAIL   = 4;

    logic       CLK = 1'b0;
    logic       RST = 1'b1;
    logic       cfg_valid = 1'b0;
    logic       cfg_ready;
    logic [5:0] cfg_n = 6'd0;
    logic [7:0] cfg_m = 8'd0;
    logic [3:0] cfg_o = 4'd0;
    logic       cfg_err;
    logic       PD;
    logic [4:0] CN;
    logic [7:0] CM;
    logic [1:0] CO;
    logic       LOCK = 1'b0;
    logic       locked;
    logic       fail;
    logic [3:0] retries;

    pll_cfg_seq #(
        .PD_CYCLES(PD_C), .LOCK_FILTER(FLT), .LOCK_TIMEOUT(TMO), .TMO_W(24), .MAX_RETRY(MAXR)
    ) dut (
        .CLK(CLK), .RST(RST), .cfg_valid(cfg_valid), .cfg_ready(cfg_ready),
        .cfg_n(cfg_n), .cfg_m(cfg_m), .cfg_o(cfg_o), .cfg_err(cfg_err),
        .PD(PD), .CN(CN), .CM(CM), .CO(CO), .LOCK(LOCK),
        .locked(locked), .fail(fail), .retries(retries)
    );

    always #5 CLK = ~CLK;

    typedef struct {
        int kind;
        int cn;
        int cm;
        int co;
        int run;
        int rtr;
        int lk;
        int fl;
    } exp_t;

    exp_t sbq[$];
    int errors = 0;
    int checks = 0;

    // reference model state
    int m_cn = 31, m_cm = 240, m_co = 0, m_locked = 0, m_fail = 0, m_rtr = 0;

    // PLL model knobs
    int pll_fail_n = 0, pll_dly = 0, pll_att = 0;
    bit drop_req = 1'b0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
        end
    endtask

    function automatic int cn_of(input int n);
        logic [4:0] v;
        if (n == 1) return 31;
        v = 5'd0;
        for (int i = 0; i < n - 2; i++) v = {v[3:0], ~(v[4] ^ v[2])};
        return int'(v);
    endfunction

    function automatic int cm_of(input int m);
        if (m < 32)  return 240 + (m - 16);
        if (m < 64)  return 192 + (m - 32);
        if (m < 128) return 128 + (m - 64);
        return m - 128;
    endfunction

    function automatic int co_of(input int o);
        return (o == 8) ? 3 : (o == 4) ? 2 : (o == 2) ? 1 : 0;
    endfunction

    function automatic bit legal_of(input int n, input int m, input int o);
        return (n >= 1) && (n <= 32) && (m >= 16) && (m <= 255) &&
               ((o == 1) || (o == 2) || (o == 4) || (o == 8));
    endfunction

    task automatic push(input int kind, input int run, input int rtr);
        exp_t e;
        e.kind = kind; e.cn = m_cn; e.cm = m_cm; e.co = m_co;
        e.run = run; e.rtr = rtr; e.lk = m_locked; e.fl = m_fail;
        sbq.push_back(e);
    endtask

    // PLL: drops LOCK whenever PD is high; locks after pll_dly cycles once the
    // attempt count for this config exceeds pll_fail_n.
    initial begin
        int  cnt;
        bit  prev_pd, prev_rdy, held;
        cnt = 0; prev_pd = 1'b1; prev_rdy = 1'b1; held = 1'b0;
        forever begin
            @(posedge CLK);
            #1;
            if (prev_rdy && !cfg_ready) pll_att = 0;
            if (PD) begin
                cnt = 0; LOCK = 1'b0; held = 1'b0;
            end else begin
                if (prev_pd) pll_att++;
                if (drop_req) begin
                    drop_req = 1'b0; held = 1'b1; LOCK = 1'b0;
                end else if (!held && pll_att > pll_fail_n) begin
                    if (cnt >= pll_dly) LOCK = 1'b1;
                    cnt++;
                end
            end
            prev_pd = PD;
            prev_rdy = cfg_ready;
        end
    end

    task automatic got(input int kind, input int hi_run);
        exp_t e;
        if (sbq.size() == 0) begin
            check("unexpected_event", kind, 99);
            return;
        end
        e = sbq.pop_front();
        check("event_kind", kind, e.kind);
        if (kind != e.kind) return;
        case (kind)
            EV_ERR: begin
                check("rej_CN", CN, e.cn);
                check("rej_CM", CM, e.cm);
                check("rej_CO", CO, e.co);
                check("rej_ready", cfg_ready, 1);
                check("rej_locked", locked, e.lk);
                check("rej_fail", fail, e.fl);
                check("rej_PD", PD, (e.lk != 0) ? 0 : 1);
            end
            EV_PDFALL: begin
                check("pd_high_cycles", hi_run, e.run);
                check("pd_CN", CN, e.cn);
                check("pd_CM", CM, e.cm);
                check("pd_CO", CO, e.co);
            end
            EV_LOCK: begin
                check("lock_CN", CN, e.cn);
                check("lock_CM", CM, e.cm);
                check("lock_CO", CO, e.co);
                check("lock_PD", PD, 0);
                check("lock_retries", retries, e.rtr);
            end
            EV_FAIL: begin
                check("fail_PD", PD, 1);
                check("fail_retries", retries, e.rtr);
            end
            default: ;
        endcase
    endtask

    initial begin
        bit prev_err, prev_locked, prev_fail, prev_pd, prev_rdy;
        int hi_run;
        prev_err = 0; prev_locked = 0; prev_fail = 0; prev_pd = 1; prev_rdy = 1; hi_run = 0;
        forever begin
            @(negedge CLK);
            if (!RST) begin
                if (cfg_err && !prev_err)      got(EV_ERR, hi_run);
                if (!locked && prev_locked)    got(EV_UNLOCK, hi_run);
                if (fail && !prev_fail)        got(EV_FAIL, hi_run);
                if (!PD && prev_pd)            got(EV_PDFALL, hi_run);
                if (locked && !prev_locked)    got(EV_LOCK, hi_run);
                if (!PD)                       hi_run = 0;
                else if (prev_rdy && !cfg_ready) hi_run = 1;
                else                           hi_run++;
            end else begin
                hi_run = 0;
            end
            prev_err = cfg_err; prev_locked = locked; prev_fail = fail;
            prev_pd = PD; prev_rdy = cfg_ready;
        end
    end

    task automatic wait_idle(input string name);
        int n = 0;
        while ((sbq.size() != 0 || !cfg_ready) && n < 3000) begin
            @(negedge CLK);
            n++;
        end
        check(name, sbq.size(), 0);
        sbq.delete();
    endtask

    task automatic do_cfg(input int n, input int m, input int o, input int fail_n, input int dly);
        int att, enc;
        wait_idle("drain_before_cfg");
        if (!legal_of(n, m, o)) begin
            push(EV_ERR, 0, 0);
        end else begin
            if (m_locked != 0) push(EV_UNLOCK, 0, 0);
            m_locked = 0; m_fail = 0;
            m_cn = cn_of(n); m_cm = cm_of(m); m_co = co_of(o);
            enc = ((n > 2) ? n - 2 : 0) + 1;
            att = (fail_n < MAXR) ? fail_n + 1 : MAXR;
            for (int a = 1; a <= att; a++) push(EV_PDFALL, (a == 1) ? enc + PD_C : PD_C, a);
            if (fail_n < MAXR) begin
                push(EV_LOCK, 0, att);
                m_locked = 1;
            end else begin
                push(EV_FAIL, 0, MAXR);
                m_fail = 1;
            end
            m_rtr = att;
            pll_fail_n = fail_n;
            pll_dly = dly;
        end
        @(negedge CLK);
        cfg_n = 6'(n); cfg_m = 8'(m); cfg_o = 4'(o); cfg_valid = 1'b1;
        @(negedge CLK);
        cfg_valid = 1'b0;
        wait_idle("drain_after_cfg");
    endtask

    task automatic drop_lock();
        if (m_locked == 0) return;
        push(EV_UNLOCK, 0, 0);
`ifdef PLL_CFG_SEQ_RELOCK_EN
        if (m_rtr < MAXR) begin
            push(EV_PDFALL, PD_C, m_rtr + 1);
            m_rtr++;
            push(EV_LOCK, 0, m_rtr);
        end else begin
            m_locked = 0;
            push(EV_FAIL, 0, m_rtr);
            m_fail = 1;
        end
`else
        m_locked = 0;
        push(EV_FAIL, 0, m_rtr);
        m_fail = 1;
`endif
        @(negedge CLK);
        drop_req = 1'b1;
        wait_idle("drain_after_drop");
    endtask

    task automatic check_reset(input string tag);
        check({tag, "_PD"}, PD, 1);
        check({tag, "_CN"}, CN, 5'b11111);
        check({tag, "_CM"}, CM, 8'b11110000);
        check({tag, "_CO"}, CO, 2'b00);
        check({tag, "_ready"}, cfg_ready, 1);
        check({tag, "_locked"}, locked, 0);
        check({tag, "_fail"}, fail, 0);
        check({tag, "_retries"}, retries, 0);
        check({tag, "_err"}, cfg_err, 0);
    endtask

    initial begin
        int n, m, o;
        int opts[4];
        opts = '{1, 2, 4, 8};
        RST = 1'b1;
        repeat (4) @(negedge CLK);
        check_reset("rst");
        RST = 1'b0;
        @(negedge CLK);
        check_reset("post_rst");

        do_cfg(5, 100, 8, 0, 5);
        check("dir_CN_5", CN, 5'b00111);
        check("dir_CM_100", CM, 8'b10100100);
        check("dir_CO_8", CO, 2'b11);
        check("dir_locked", locked, 1);

        do_cfg(32, 255, 1, 0, 10);
        check("dir_CN_32", CN, 5'b10000);
        check("dir_CM_255", CM, 8'b01111111);
        check("dir_CO_1", CO, 2'b00);

        do_cfg(5, 15, 1, 0, 0);
        do_cfg(5, 100, 3, 0, 0);
        do_cfg(0, 100, 2, 0, 0);
        do_cfg(33, 100, 2, 0, 0);

        do_cfg(7, 64, 2, 3, 0);
        check("dir_fail", fail, 1);
        check("dir_fail_retries", retries, 3);
        do_cfg(9, 200, 4, 0, 0);

        do_cfg(1, 16, 4, 1, 20);
        drop_lock();
        do_cfg(2, 31, 8, 2, 0);
        drop_lock();

        // Reset in WAIT_LOCK must force PD high and restore the reset codes.
        do_cfg(10, 50, 2, 0, 3);
        pll_fail_n = 3;
        begin
            int k = 0;
            m_locked = 0; m_fail = 0; m_cn = cn_of(12); m_cm = cm_of(60); m_co = co_of(4);
            push(EV_UNLOCK, 0, 0);
            push(EV_PDFALL, 10 + 1 + PD_C, 1);
            push(EV_PDFALL, PD_C, 2);
            push(EV_PDFALL, PD_C, 3);
            @(negedge CLK);
            cfg_n = 6'd12; cfg_m = 8'd60; cfg_o = 4'd4; cfg_valid = 1'b1;
            @(negedge CLK);
            cfg_valid = 1'b0;
            while (sbq.size() > 2 && k < 500) begin
                @(negedge CLK);
                k++;
            end
            check("mid_rst_reach_wait", sbq.size(), 2);
            @(negedge CLK);
            RST = 1'b1;
            sbq.delete();
            @(negedge CLK);
            check_reset("mid_rst");
            RST = 1'b0;
            m_cn = 31; m_cm = 240; m_co = 0; m_locked = 0; m_fail = 0; m_rtr = 0;
            @(negedge CLK);
        end

        for (int t = 0; t < 24; t++) begin
            n = $urandom_range(0, 34);
            m = ($urandom_range(0, 3) == 0) ? $urandom_range(0, 20) : $urandom_range(16, 255);
            o = ($urandom_range(0, 4) == 0) ? $urandom_range(0, 15) : opts[$urandom_range(0, 3)];
            do_cfg(n, m, o, $urandom_range(0, 3), $urandom_range(0, 40));
            if ($urandom_range(0, 2) == 0) drop_lock();
        end

        wait_idle("final_drain");
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
